// File: rtl/muldiv_ctrl.sv
// RV32M EX-stage sequencer: holds operands on the external multiplier for its latency
// and runs div/divu/rem/remu on an internal radix-2 restoring divider.
module muldiv_ctrl #(
    parameter int MUL_LATENCY = 3,
    parameter int XLEN        = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic [XLEN-1:0] mul_rs1,
    output logic [XLEN-1:0] mul_rs2,
    output logic [2:0]      mul_funct3,
    input  logic [XLEN-1:0] mul_out,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CNT_MAX = (MUL_LATENCY > XLEN) ? MUL_LATENCY : XLEN;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_LATENCY - 1);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL_WAIT,
        S_DIV_RUN,
        S_DIV_FIX,
        S_DONE
    } state_t;

    state_t r_state, w_next;

    logic [XLEN-1:0]  r_rs1, r_rs2, r_rem, r_quot, r_div, r_result;
    logic [2:0]       r_funct3;
    logic [CNT_W-1:0] r_cnt;
    logic             r_qneg, r_rneg;

    logic            w_accept, w_signed, w_rs1_neg, w_rs2_neg;
    logic            w_div_zero, w_overflow, w_special, w_ge;
    logic [XLEN-1:0] w_abs_rs1, w_abs_rs2, w_sub, w_fix_val;
    logic [XLEN:0]   w_shift;

    assign w_accept   = (r_state == S_IDLE) && start && !flush;
    assign w_signed   = !funct3[0];
    assign w_rs1_neg  = w_signed && rs1_data[XLEN-1];
    assign w_rs2_neg  = w_signed && rs2_data[XLEN-1];
    assign w_abs_rs1  = w_rs1_neg ? (~rs1_data + 1'b1) : rs1_data;
    assign w_abs_rs2  = w_rs2_neg ? (~rs2_data + 1'b1) : rs2_data;
    assign w_div_zero = (rs2_data == '0);
    assign w_overflow = w_signed && (rs1_data == INT_MIN) && (rs2_data == '1);
    assign w_special  = w_div_zero || w_overflow;

    // 33-bit compare lets divisors >= 2^31 work; when it succeeds the true
    // difference is below the divisor, so the low XLEN bits of the subtract are exact.
    assign w_shift = {r_rem, r_quot[XLEN-1]};
    assign w_ge    = (w_shift >= {1'b0, r_div});
    assign w_sub   = w_shift[XLEN-1:0] - r_div;

    assign w_fix_val = r_funct3[1] ? (r_rneg ? (~r_rem  + 1'b1) : r_rem)
                                   : (r_qneg ? (~r_quot + 1'b1) : r_quot);

    assign mul_rs1    = r_rs1;
    assign mul_rs2    = r_rs2;
    assign mul_funct3 = r_funct3;
    assign result     = r_result;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // NOTE: every output of this block gets a default first so no path leaves a latch.
    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept)
                    w_next = !funct3[2] ? S_MUL_WAIT : (w_special ? S_DIV_FIX : S_DIV_RUN);
            end
            S_MUL_WAIT: begin
                busy = 1'b1;
                if (r_cnt == MUL_LAST) w_next = S_DONE;
            end
            S_DIV_RUN: begin
                busy = 1'b1;
                if (r_cnt == DIV_LAST) w_next = S_DIV_FIX;
            end
            S_DIV_FIX: begin
                busy   = 1'b1;
                w_next = S_DONE;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
        if (flush) w_next = S_IDLE;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rs1    <= '0;
            r_rs2    <= '0;
            r_funct3 <= '0;
            r_rem    <= '0;
            r_quot   <= '0;
            r_div    <= '0;
            r_result <= '0;
            r_cnt    <= '0;
            r_qneg   <= 1'b0;
            r_rneg   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_rs1    <= rs1_data;
                        r_rs2    <= rs2_data;
                        r_funct3 <= funct3;
                        r_cnt    <= '0;
                        r_div    <= w_abs_rs2;
                        // Special cases preload the final values and pass through DIV_FIX unchanged.
                        if (w_div_zero) begin
                            r_quot <= '1;
                            r_rem  <= rs1_data;
                            r_qneg <= 1'b0;
                            r_rneg <= 1'b0;
                        end else if (w_overflow) begin
                            r_quot <= INT_MIN;
                            r_rem  <= '0;
                            r_qneg <= 1'b0;
                            r_rneg <= 1'b0;
                        end else begin
                            r_quot <= w_abs_rs1;
                            r_rem  <= '0;
                            r_qneg <= w_rs1_neg ^ w_rs2_neg;
                            r_rneg <= w_rs1_neg;
                        end
                    end
                end
                S_MUL_WAIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == MUL_LAST && !flush) r_result <= mul_out;
                end
                S_DIV_RUN: begin
                    r_cnt  <= r_cnt + 1'b1;
                    r_rem  <= w_ge ? w_sub : w_shift[XLEN-1:0];
                    r_quot <= {r_quot[XLEN-2:0], w_ge};
                end
                S_DIV_FIX: begin
                    if (!flush) r_result <= w_fix_val;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed vector table, randomized ops against an
// arithmetic reference model, and hand-written flush/reset/DONE-cycle sequences.
module tb_muldiv_ctrl;

    localparam int MUL_LATENCY = 3;
    localparam logic [31:0] INT_MIN = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst, start, flush, busy, done;
    logic [2:0]  funct3, mul_funct3;
    logic [31:0] rs1_data, rs2_data, mul_rs1, mul_rs2, mul_out, result;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    muldiv_ctrl #(.MUL_LATENCY(MUL_LATENCY), .XLEN(32)) dut (
        .clk(clk), .rst(rst), .start(start), .flush(flush), .funct3(funct3),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .mul_rs1(mul_rs1), .mul_rs2(mul_rs2),
        .mul_funct3(mul_funct3), .mul_out(mul_out), .busy(busy), .done(done), .result(result)
    );

    // RV32M semantics computed with plain 64-bit / integer arithmetic.
    function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] b);
        logic [63:0] sa, sb, ua, ub, p;
        int ia, ib;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'b0, a};
        ub = {32'b0, b};
        ia = a;
        ib = b;
        p  = '0;
        case (f3)
            3'd0: begin p = ua * ub; return p[31:0];  end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == INT_MIN && b == 32'hFFFF_FFFF) return INT_MIN;
                return ia / ib;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == INT_MIN && b == 32'hFFFF_FFFF) return 32'h0;
                return ia % ib;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_cycles(input logic [2:0] f3, input logic [31:0] a,
                                      input logic [31:0] b);
        if (!f3[2]) return MUL_LATENCY + 1;
        if (b == 0) return 2;
        if (!f3[0] && a == INT_MIN && b == 32'hFFFF_FFFF) return 2;
        return 34;
    endfunction

    // Stand-in for the Dadda multiplier: result of the inputs seen MUL_LATENCY-1 edges ago.
    logic [31:0] mul_stage [MUL_LATENCY-1];
    always @(posedge clk) begin
        mul_stage[0] <= ref_model({1'b0, mul_funct3[1:0]}, mul_rs1, mul_rs2);
        for (int i = 1; i < MUL_LATENCY - 1; i++) mul_stage[i] <= mul_stage[i-1];
    end
    assign mul_out = mul_stage[MUL_LATENCY-2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
        else             n_pass++;
    endtask

    // Called at posedge+1 of cycle 0; returns at posedge+1 two cycles after done.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input int exp_cyc, input string name);
        int          done_cyc = -1;
        logic [31:0] res_at_done = '0;
        bit          busy_ok = 1'b1;
        bit          ops_ok  = 1'b1;
        start = 1'b1; funct3 = f3; rs1_data = a; rs2_data = b;
        @(posedge clk); #1;
        start = 1'b0; funct3 = 3'($urandom); rs1_data = $urandom; rs2_data = $urandom;
        for (int cyc = 1; cyc <= 60 && done_cyc < 0; cyc++) begin
            @(negedge clk);
            if (done) begin
                done_cyc    = cyc;
                res_at_done = result;
                if (busy) busy_ok = 1'b0;
            end else begin
                if (!busy) busy_ok = 1'b0;
                if (!f3[2] && (mul_rs1 !== a || mul_rs2 !== b || mul_funct3 !== f3)) ops_ok = 1'b0;
            end
            @(posedge clk); #1;
        end
        check({name, " done cycle"}, done_cyc, exp_cyc);
        check({name, " result"}, res_at_done, exp_res);
        check({name, " busy until done"}, {31'b0, busy_ok}, 32'd1);
        if (!f3[2]) check({name, " mul operands held"}, {31'b0, ops_ok}, 32'd1);
        @(negedge clk);
        check({name, " single done pulse"}, {30'b0, done, busy}, 32'd0);
        check({name, " result held"}, result, exp_res);
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_res;
        int          exp_cyc;
        string       name;
    } vec_t;

    vec_t vecs [17];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [2:0]  f3;
        logic [31:0] a, b;
        int          sel;

        vecs[0]  = '{3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 4,  "mul 7*-3"};
        vecs[1]  = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 4,  "mulhu max"};
        vecs[2]  = '{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 4,  "mulh min*min"};
        vecs[3]  = '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4,  "mulhsu -1*max"};
        vecs[4]  = '{3'b100, 32'hFFFF_FF9C, 32'h0000_0007, 32'hFFFF_FFF2, 34, "div -100/7"};
        vecs[5]  = '{3'b110, 32'hFFFF_FF9C, 32'h0000_0007, 32'hFFFF_FFFE, 34, "rem -100/7"};
        vecs[6]  = '{3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 34, "divu big divisor"};
        vecs[7]  = '{3'b111, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 2,  "remu by zero"};
        vecs[8]  = '{3'b101, 32'h1234_5678, 32'h0000_0000, 32'hFFFF_FFFF, 2,  "divu by zero"};
        vecs[9]  = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2,  "div overflow"};
        vecs[10] = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 2,  "rem overflow"};
        vecs[11] = '{3'b100, 32'h0000_0064, 32'h0000_0000, 32'hFFFF_FFFF, 2,  "div by zero"};
        vecs[12] = '{3'b110, 32'hFFFF_FF9C, 32'h0000_0000, 32'hFFFF_FF9C, 2,  "rem by zero"};
        vecs[13] = '{3'b101, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0001, 34, "divu max/2^31"};
        vecs[14] = '{3'b111, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 34, "remu max/2^31"};
        vecs[15] = '{3'b100, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 34, "div 7/-2"};
        vecs[16] = '{3'b110, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 34, "rem 7/-2"};

        rst = 1'b1; start = 1'b0; flush = 1'b0; funct3 = '0; rs1_data = '0; rs2_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset busy", {31'b0, busy}, 32'd0);
        check("reset done", {31'b0, done}, 32'd0);
        check("reset result", result, 32'd0);
        check("reset mul_rs1", mul_rs1, 32'd0);
        check("reset mul_rs2", mul_rs2, 32'd0);
        check("reset mul_funct3", {29'b0, mul_funct3}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 17; i++)
            run_op(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp_res, vecs[i].exp_cyc, vecs[i].name);

        for (int i = 0; i < 40; i++) begin
            f3  = 3'($urandom_range(0, 7));
            a   = $urandom;
            b   = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0) b = '0;
            else if (sel == 1) begin a = INT_MIN; b = 32'hFFFF_FFFF; end
            else if (sel == 2) b = $urandom_range(1, 15);
            else if (sel == 3) a = -a;
            run_op(f3, a, b, ref_model(f3, a, b), ref_cycles(f3, a, b), $sformatf("rand%0d f3=%0d", i, f3));
        end

        // Flush mid-divide: no done pulse, result keeps the previous value.
        run_op(3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 4, "mul before flush");
        start = 1'b1; funct3 = 3'b101; rs1_data = 32'h0000_1000; rs2_data = 32'h0000_0003;
        @(posedge clk); #1;
        start = 1'b0;
        sel = 0;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            if (cyc == 10) flush = 1'b1;
            @(negedge clk);
            if (done) sel++;
            @(posedge clk); #1;
        end
        flush = 1'b0;
        @(negedge clk);
        check("flush no done", sel, 32'd0);
        check("flush idle busy", {30'b0, busy, done}, 32'd0);
        check("flush result kept", result, 32'hFFFF_FFEB);
        @(posedge clk); #1;
        run_op(3'b000, 32'h0000_0003, 32'h0000_0005, 32'h0000_000F, 4, "mul after flush");

        // flush and start together in IDLE: the start is dropped.
        start = 1'b1; flush = 1'b1; funct3 = 3'b101; rs1_data = 32'h1; rs2_data = 32'h0;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        @(negedge clk);
        check("flush+start busy", {31'b0, busy}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("flush+start done", {31'b0, done}, 32'd0);
        check("flush+start result", result, 32'h0000_000F);
        @(posedge clk); #1;

        // start presented during the DONE cycle is ignored.
        start = 1'b1; funct3 = 3'b000; rs1_data = 32'h0000_0002; rs2_data = 32'h0000_0009;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        start = 1'b1; funct3 = 3'b101; rs1_data = 32'h0000_0064; rs2_data = 32'h0000_0000;
        @(negedge clk);
        check("done-cycle done", {31'b0, done}, 32'd1);
        check("done-cycle result", result, 32'h0000_0012);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("start in done ignored", {30'b0, busy, done}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("start in done no op", {30'b0, busy, done}, 32'd0);
        @(posedge clk); #1;

        // Reset in the middle of a divide.
        start = 1'b1; funct3 = 3'b100; rs1_data = 32'hFFFF_0000; rs2_data = 32'h0000_0013;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid-op reset busy/done", {30'b0, busy, done}, 32'd0);
        check("mid-op reset result", result, 32'd0);
        check("mid-op reset mul_rs1", mul_rs1, 32'd0);
        check("mid-op reset mul_rs2", mul_rs2, 32'd0);
        check("mid-op reset mul_funct3", {29'b0, mul_funct3}, 32'd0);
        @(posedge clk); #1;
        run_op(3'b110, 32'h0000_0064, 32'hFFFF_FFF9, 32'h0000_0002, 34, "rem after reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
